// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: sequences an IxJ by JxK float matrix multiply through one
// shared external vec_dot unit. One row/column pair is issued per cycle in
// row-major order. Each issue is tagged with its output index, and that tag
// travels down a pipeline that matches the dot-product latency, so every
// returning result lands in the correct output element. Float words are
// routed only; no arithmetic is done on them.
module mat_mul_ctrl #(
   parameter int EXP_WIDTH   = 8,
   parameter int MANT_WIDTH  = 23,
   parameter int I           = 4,
   parameter int J           = 4,
   parameter int K           = 4,
   parameter int DOT_LATENCY = 3,
   localparam int FW         = 1 + EXP_WIDTH + MANT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [I*J*FW-1:0] i_lhs,
   input  logic [J*K*FW-1:0] i_rhs,
   output logic              o_busy,
   output logic              o_done,
   output logic [I*K*FW-1:0] o_out,
   output logic [J*FW-1:0]   o_dot_lhs,
   output logic [J*FW-1:0]   o_dot_rhs,
   input  logic [FW-1:0]     i_dot_result
);

   localparam int N  = I * K;
   localparam int RW = (I > 1) ? $clog2(I) : 1;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam int XW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = (DOT_LATENCY > 1) ? $clog2(DOT_LATENCY) : 1;

   localparam logic [RW-1:0] ROW_LAST   = RW'(I - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(K - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((DOT_LATENCY > 0) ? DOT_LATENCY - 1 : 0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]          r_state;
   logic [RW-1:0]       r_row;
   logic [CW-1:0]       r_col;
   logic [XW-1:0]       r_idx;
   logic [DW-1:0]       r_drain;
   logic [I*J*FW-1:0]   r_lhs;
   logic [J*K*FW-1:0]   r_rhs;
   logic [FW-1:0]       r_out [N];

   logic                w_accept;
   logic                w_issue;
   logic                w_last_issue;
   logic                w_wr_vld;
   logic [XW-1:0]       w_wr_idx;

   // A new run may begin from IDLE, or back-to-back from the DONE cycle.
   assign w_accept     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_issue      = (r_state == S_ISSUE);
   assign w_last_issue = w_issue && (r_row == ROW_LAST) && (r_col == COL_LAST);

   assign o_busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign o_done = (r_state == S_DONE);

   // Control FSM. The row/col counters step row-major, with col wrapping into
   // row, so no divider is needed. r_idx is the matching linear index.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_idx   <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_state <= S_ISSUE;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_idx   <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ISSUE: begin
               if (w_last_issue) begin
                  r_row   <= '0;
                  r_col   <= '0;
                  r_idx   <= '0;
                  r_drain <= '0;
                  r_state <= (DOT_LATENCY == 0) ? S_DONE : S_DRAIN;
               end else begin
                  r_idx <= r_idx + XW'(1);
                  if (r_col == COL_LAST) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain == DRAIN_LAST) begin
                  r_state <= S_DONE;
               end else begin
                  r_drain <= r_drain + DW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Capture the operands on the accept edge only. Later start pulses or
   // operand changes during a run are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lhs <= '0;
         r_rhs <= '0;
      end else if (w_accept) begin
         r_lhs <= i_lhs;
         r_rhs <= i_rhs;
      end
   end

   // Drive the current lhs row and rhs column to vec_dot while issuing.
   // Drive zero at all other times.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      o_dot_lhs = '0;
      o_dot_rhs = '0;
      if (w_issue) begin
         o_dot_lhs = r_lhs[int'(r_row) * (J * FW) +: J * FW];
         for (int j = 0; j < J; j++) begin
            o_dot_rhs[j * FW +: FW] = r_rhs[(j * K + int'(r_col)) * FW +: FW];
         end
      end
   end

   generate
      if (DOT_LATENCY == 0) begin : g_no_pipe
         // A zero-latency vec_dot answers in the issue cycle itself.
         assign w_wr_vld = w_issue;
         assign w_wr_idx = r_idx;
      end else begin : g_pipe
         logic [DOT_LATENCY-1:0] r_pipe_vld;
         logic [XW-1:0]          r_pipe_idx [DOT_LATENCY];

         // Valid/index tag pipeline, aligned with the vec_dot latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pipe_vld <= '0;
               for (int s = 0; s < DOT_LATENCY; s++) begin
                  r_pipe_idx[s] <= '0;
               end
            end else begin
               r_pipe_vld[0] <= w_issue;
               r_pipe_idx[0] <= r_idx;
               for (int s = 1; s < DOT_LATENCY; s++) begin
                  r_pipe_vld[s] <= r_pipe_vld[s-1];
                  r_pipe_idx[s] <= r_pipe_idx[s-1];
               end
            end
         end

         assign w_wr_vld = r_pipe_vld[DOT_LATENCY-1];
         assign w_wr_idx = r_pipe_idx[DOT_LATENCY-1];
      end
   endgenerate

   // Result matrix. It is written only by tagged returning dot results, and
   // holds its value at all other times.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the result array is flip-flops that must read zero after reset, so each entry is cleared here.
         for (int e = 0; e < N; e++) begin
            r_out[e] <= '0;
         end
      end else if (w_wr_vld) begin
         r_out[w_wr_idx] <= i_dot_result;
      end
   end

   generate
      for (genvar e = 0; e < N; e++) begin : g_out_pack
         assign o_out[e * FW +: FW] = r_out[e];
      end
   endgenerate

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// tb_mat_mul_ctrl: directed bench for mat_mul_ctrl at 2x2x2 with 32-bit floats.
// Instance a uses DOT_LATENCY=3 and instance b uses DOT_LATENCY=0. Each
// instance has its own vec_dot model. The model decodes the small integer
// floats, accumulates the dot product and re-encodes the sum.
module tb_mat_mul_ctrl;

   localparam int FW  = 32;
   localparam int I   = 2;
   localparam int J   = 2;
   localparam int K   = 2;
   localparam int LAT = 3;

   localparam logic [31:0] F1  = 32'h3F800000;
   localparam logic [31:0] F2  = 32'h40000000;
   localparam logic [31:0] F3  = 32'h40400000;
   localparam logic [31:0] F4  = 32'h40800000;
   localparam logic [31:0] F5  = 32'h40A00000;
   localparam logic [31:0] F6  = 32'h40C00000;
   localparam logic [31:0] F7  = 32'h40E00000;
   localparam logic [31:0] F8  = 32'h41000000;
   localparam logic [31:0] F12 = 32'h41400000;

   localparam logic [63:0]  ROW0 = {F2, F1};
   localparam logic [63:0]  ROW1 = {F4, F3};
   localparam logic [63:0]  COL0 = {F7, F5};
   localparam logic [63:0]  COL1 = {F8, F6};
   localparam logic [127:0] OUT1 = {32'h42480000, 32'h422C0000, 32'h41B00000, 32'h41980000};
   localparam logic [127:0] OUT2 = {F6, F4, F6, F4};
   localparam logic [127:0] OUT3 = {F12, F8, F12, F8};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              start_a, start_b;
   logic [I*J*FW-1:0] lhs_a, lhs_b;
   logic [J*K*FW-1:0] rhs_a, rhs_b;
   logic              busy_a, done_a, busy_b, done_b;
   logic [I*K*FW-1:0] out_a, out_b;
   logic [J*FW-1:0]   dl_a, dr_a, dl_b, dr_b;
   logic [FW-1:0]     res_a, res_b;

   int checks = 0;
   int errors = 0;

   mat_mul_ctrl #(.EXP_WIDTH(8), .MANT_WIDTH(23), .I(I), .J(J), .K(K), .DOT_LATENCY(LAT)) u_dut_a (
      .clk(clk), .rst(rst), .i_start(start_a), .i_lhs(lhs_a), .i_rhs(rhs_a),
      .o_busy(busy_a), .o_done(done_a), .o_out(out_a),
      .o_dot_lhs(dl_a), .o_dot_rhs(dr_a), .i_dot_result(res_a)
   );

   mat_mul_ctrl #(.EXP_WIDTH(8), .MANT_WIDTH(23), .I(I), .J(J), .K(K), .DOT_LATENCY(0)) u_dut_b (
      .clk(clk), .rst(rst), .i_start(start_b), .i_lhs(lhs_b), .i_rhs(rhs_b),
      .o_busy(busy_b), .o_done(done_b), .o_out(out_b),
      .o_dot_lhs(dl_b), .o_dot_rhs(dr_b), .i_dot_result(res_b)
   );

   // Decode a non-negative integer-valued single-precision float.
   function automatic int f2i(logic [31:0] f);
      int e;
      e = int'(f[30:23]);
      if (e == 0) return 0;
      return int'({8'd0, 1'b1, f[22:0]} >> (150 - e));
   endfunction

   // Encode a small non-negative integer as a single-precision float.
   function automatic logic [31:0] i2f(int n);
      int          p;
      logic [31:0] m;
      p = 0;
      if (n <= 0) return 32'd0;
      for (int b = 0; b < 24; b++) if (n[b]) p = b;
      m = 32'(n) << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   function automatic logic [31:0] dot(logic [J*FW-1:0] a, logic [J*FW-1:0] b);
      int s;
      s = 0;
      for (int j = 0; j < J; j++) s += f2i(a[j*FW +: FW]) * f2i(b[j*FW +: FW]);
      return i2f(s);
   endfunction

   // vec_dot model with a 3-cycle latency.
   logic [31:0] pipe_a [LAT];
   always @(posedge clk) begin
      pipe_a[0] <= dot(dl_a, dr_a);
      for (int s = 1; s < LAT; s++) pipe_a[s] <= pipe_a[s-1];
   end
   assign res_a = pipe_a[LAT-1];

   // vec_dot model with zero latency.
   assign res_b = dot(dl_b, dr_b);

   function automatic logic [63:0] exp_dl(int c);
      if (c == 1 || c == 2) return ROW0;
      if (c == 3 || c == 4) return ROW1;
      return 64'd0;
   endfunction

   function automatic logic [63:0] exp_dr(int c);
      if (c == 1 || c == 3) return COL0;
      if (c == 2 || c == 4) return COL1;
      return 64'd0;
   endfunction

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      lhs_a   = '0;
      rhs_a   = '0;
      lhs_b   = '0;
      rhs_b   = '0;
      tick();
      tick();

      // Reset state of both instances.
      check("rst_busy_a", 128'(busy_a), 128'(0));
      check("rst_done_a", 128'(done_a), 128'(0));
      check("rst_out_a",  128'(out_a),  128'(0));
      check("rst_dl_a",   128'(dl_a),   128'(0));
      check("rst_dr_a",   128'(dr_a),   128'(0));
      check("rst_out_b",  128'(out_b),  128'(0));
      rst = 1'b0;
      tick();

      // Basic run: a single start pulse in cycle 0.
      lhs_a   = {F4, F3, F2, F1};
      rhs_a   = {F8, F7, F6, F5};
      start_a = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) start_a = 1'b0;
         check($sformatf("t1_busy_c%0d", c), 128'(busy_a), 128'(c <= 7));
         check($sformatf("t1_done_c%0d", c), 128'(done_a), 128'(c == 8));
         check($sformatf("t1_dl_c%0d", c),   128'(dl_a),   128'(exp_dl(c)));
         check($sformatf("t1_dr_c%0d", c),   128'(dr_a),   128'(exp_dr(c)));
      end
      check("t1_out", 128'(out_a), OUT1);

      // Idle for 20 cycles with start low.
      for (int c = 1; c <= 20; c++) begin
         tick();
         check($sformatf("idle_busy_c%0d", c), 128'(busy_a), 128'(0));
         check($sformatf("idle_done_c%0d", c), 128'(done_a), 128'(0));
         check($sformatf("idle_out_c%0d", c),  128'(out_a),  OUT1);
         check($sformatf("idle_dl_c%0d", c),   128'(dl_a),   128'(0));
         check($sformatf("idle_dr_c%0d", c),   128'(dr_a),   128'(0));
      end

      // Start held high throughout, with lhs changed mid-run. Run 2 keeps
      // its captured operands. Run 3 is accepted in the done cycle with the
      // new lhs.
      lhs_a   = {F1, F1, F1, F1};
      rhs_a   = {F4, F3, F2, F1};
      start_a = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         tick();
         if (c == 3)  lhs_a = {F2, F2, F2, F2};
         if (c == 16) start_a = 1'b0;
         check($sformatf("t2_done_c%0d", c), 128'(done_a), 128'(c == 8 || c == 16));
         check($sformatf("t2_busy_c%0d", c), 128'(busy_a), 128'(c != 8 && c < 16));
         if (c == 8)  check("t2_out_run2", 128'(out_a), OUT2);
         if (c == 16) check("t2_out_run3", 128'(out_a), OUT3);
      end

      // Reset asserted in cycle 5 of a run, then a quiet period after release.
      lhs_a   = {F4, F3, F2, F1};
      rhs_a   = {F8, F7, F6, F5};
      start_a = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start_a = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("t3_rst_busy", 128'(busy_a), 128'(0));
      check("t3_rst_done", 128'(done_a), 128'(0));
      check("t3_rst_out",  128'(out_a),  128'(0));
      check("t3_rst_dl",   128'(dl_a),   128'(0));
      check("t3_rst_dr",   128'(dr_a),   128'(0));
      tick();
      rst = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         check($sformatf("t3_post_done_c%0d", c), 128'(done_a), 128'(0));
         check($sformatf("t3_post_busy_c%0d", c), 128'(busy_a), 128'(0));
         check($sformatf("t3_post_out_c%0d", c),  128'(out_a),  128'(0));
      end

      // Zero-latency instance: done in cycle 5, with no drain cycle.
      lhs_b   = {F4, F3, F2, F1};
      rhs_b   = {F8, F7, F6, F5};
      start_b = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) start_b = 1'b0;
         check($sformatf("t4_busy_c%0d", c), 128'(busy_b), 128'(c <= 4));
         check($sformatf("t4_done_c%0d", c), 128'(done_b), 128'(c == 5));
         check($sformatf("t4_dl_c%0d", c),   128'(dl_b),   128'(exp_dl(c)));
         check($sformatf("t4_dr_c%0d", c),   128'(dr_b),   128'(exp_dr(c)));
         if (c == 5) check("t4_out", 128'(out_b), OUT1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
